// File: rtl/reg_bank_pkg.sv
// Shared definitions for the reg_bank_io register bank: default special
// register addresses and the address-width helper.
package reg_bank_pkg;

    localparam int DEF_PIN_ADDR  = 10;
    localparam int DEF_POUT_ADDR = 11;
    localparam int DEF_RLD_ADDR  = 12;
    localparam int DEF_TMR_ADDR  = 13;

    // Address width needed to select one of n registers (at least 1 bit).
    function automatic int ADDR_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_io_if.sv
// Bus between the datapath and the register bank: one write port, two
// read ports, the external pin buses and the timer strobe/pulse.
interface reg_bank_io_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
);
    import reg_bank_pkg::*;

    localparam int AW = ADDR_W(NUM_REGS);

    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     raddr_a;
    logic [AW-1:0]     raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] pin_in;
    logic [DATA_W-1:0] port_out;
    logic              tmr_tick;
    logic              tmr_expire;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, pin_in, tmr_tick,
        input  rdata_a, rdata_b, port_out, tmr_expire
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, pin_in, tmr_tick,
        output rdata_a, rdata_b, port_out, tmr_expire
    );

endinterface

// File: rtl/reg_bank_timer.sv
// Reloadable down-counter: TMR counts down on each tick, reloads from RLD
// when a tick arrives at zero, and raises a registered one-cycle expire pulse.
module reg_bank_timer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rld_we_i,
    input  logic              tmr_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              tick_i,
    output logic [DATA_W-1:0] rld_o,
    output logic [DATA_W-1:0] tmr_o,
    output logic              expire_o
);

    logic [DATA_W-1:0] rld_q, rld_d;
    logic [DATA_W-1:0] tmr_q, tmr_d;
    logic              expire_q, expire_d;

    // Next-state: a TMR write beats the tick; reload uses the RLD value
    // held before any same-cycle RLD write.
    always_comb begin
        rld_d    = rld_q;
        tmr_d    = tmr_q;
        expire_d = 1'b0;
        if (rld_we_i) begin
            rld_d = wdata_i;
        end
        if (tmr_we_i) begin
            tmr_d = wdata_i;
        end else if (tick_i) begin
            if (tmr_q == '0) begin
                tmr_d    = rld_q;
                expire_d = 1'b1;
            end else begin
                tmr_d = tmr_q - DATA_W'(1);
            end
        end
    end

    // Timer state registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rld_q    <= '0;
            tmr_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            rld_q    <= rld_d;
            tmr_q    <= tmr_d;
            expire_q <= expire_d;
        end
    end

    assign rld_o    = rld_q;
    assign tmr_o    = tmr_q;
    assign expire_o = expire_q;

endmodule

// File: rtl/reg_bank_io.sv
// Register bank with two combinational read ports, one write port and
// memory-mapped PIN/POUT/timer registers at fixed addresses.
module reg_bank_io
    import reg_bank_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 16,
    parameter int PIN_ADDR  = DEF_PIN_ADDR,
    parameter int POUT_ADDR = DEF_POUT_ADDR,
    parameter int RLD_ADDR  = DEF_RLD_ADDR,
    parameter int TMR_ADDR  = DEF_TMR_ADDR,
    parameter int BYPASS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_bank_io_if.slave  bus
);

    localparam int AW = ADDR_W(NUM_REGS);
    localparam logic [AW-1:0] PIN_A = AW'(PIN_ADDR);
    localparam logic [AW-1:0] RLD_A = AW'(RLD_ADDR);
    localparam logic [AW-1:0] TMR_A = AW'(TMR_ADDR);

    if (NUM_REGS < 4 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_chk_num
        $fatal(1, "reg_bank_io: NUM_REGS must be a power of two and >= 4");
    end
    if (PIN_ADDR >= NUM_REGS || POUT_ADDR >= NUM_REGS ||
        RLD_ADDR >= NUM_REGS || TMR_ADDR >= NUM_REGS) begin : g_chk_range
        $fatal(1, "reg_bank_io: special address out of range");
    end
    if (PIN_ADDR == POUT_ADDR || PIN_ADDR == RLD_ADDR || PIN_ADDR == TMR_ADDR ||
        POUT_ADDR == RLD_ADDR || POUT_ADDR == TMR_ADDR ||
        RLD_ADDR == TMR_ADDR) begin : g_chk_unique
        $fatal(1, "reg_bank_io: special addresses must be distinct");
    end

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wsel;
    logic [DATA_W-1:0]   rld_val;
    logic [DATA_W-1:0]   tmr_val;
    logic                tmr_expire;

    // Read mux for one port: stored word, timer registers live in the
    // sub-module, and bypass skips PIN (read-only) and TMR (tick-owned).
    function automatic logic [DATA_W-1:0] read_port(
        input logic [AW-1:0]     ra,
        input logic [DATA_W-1:0] stored,
        input logic [DATA_W-1:0] rld,
        input logic [DATA_W-1:0] tmr,
        input logic              we,
        input logic [AW-1:0]     wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] r;
        r = stored;
        if (ra == RLD_A) r = rld;
        if (ra == TMR_A) r = tmr;
        if (BYPASS != 0 && we && wa == ra && wa != PIN_A && wa != TMR_A) begin
            r = wd;
        end
        return r;
    endfunction

    // One-hot write select decoded straight from the request.
    always_comb begin
        wsel = '0;
        if (bus.we) begin
            wsel[bus.waddr] = 1'b1;
        end
    end

    // General storage; the PIN slot samples pin_in every cycle and the
    // timer slots are held by the sub-module instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == PIN_ADDR) begin
                    regs_q[i] <= bus.pin_in;
                end else if (i != RLD_ADDR && i != TMR_ADDR && wsel[i]) begin
                    regs_q[i] <= bus.wdata;
                end
            end
        end
    end

    reg_bank_timer #(
        .DATA_W (DATA_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .rld_we_i (wsel[RLD_ADDR]),
        .tmr_we_i (wsel[TMR_ADDR]),
        .wdata_i  (bus.wdata),
        .tick_i   (bus.tmr_tick),
        .rld_o    (rld_val),
        .tmr_o    (tmr_val),
        .expire_o (tmr_expire)
    );

    assign bus.rdata_a = read_port(bus.raddr_a, regs_q[bus.raddr_a], rld_val, tmr_val,
                                   bus.we, bus.waddr, bus.wdata);
    assign bus.rdata_b = read_port(bus.raddr_b, regs_q[bus.raddr_b], rld_val, tmr_val,
                                   bus.we, bus.waddr, bus.wdata);
    assign bus.port_out   = regs_q[POUT_ADDR];
    assign bus.tmr_expire = tmr_expire;

endmodule
